// File: rtl/sobel_window_gen.sv
// Sobel 3x3 window generator: two line buffers plus a registered window.
// Emits a window strobe only where the full neighbourhood lies inside the frame.
module sobel_window_gen #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int PIX_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pixel_i,
   input  logic             pixel_valid_i,
   input  logic             sof_i,
   output logic [PIX_W-1:0] data_0_0_o,
   output logic [PIX_W-1:0] data_0_1_o,
   output logic [PIX_W-1:0] data_0_2_o,
   output logic [PIX_W-1:0] data_1_0_o,
   output logic [PIX_W-1:0] data_1_1_o,
   output logic [PIX_W-1:0] data_1_2_o,
   output logic [PIX_W-1:0] data_2_0_o,
   output logic [PIX_W-1:0] data_2_1_o,
   output logic [PIX_W-1:0] data_2_2_o,
   output logic             win_valid_o,
   output logic             frame_done_o
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0]    col, cur_c, nxt_c;
   logic [RW-1:0]    row, cur_r, nxt_r;
   logic             accept, col_end, last_px, in_core;
   logic [PIX_W-1:0] lb0 [IMG_W];
   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] lb0_rd, lb1_rd;
   logic [PIX_W-1:0] win [3][3];

   // sof overrides the counters so the accepted pixel lands on (0,0)
   always_comb begin
      accept  = pixel_valid_i;
      cur_c   = sof_i ? '0 : col;
      cur_r   = sof_i ? '0 : row;
      col_end = (cur_c == CW'(IMG_W - 1));
      last_px = col_end && (cur_r == RW'(IMG_H - 1));
      in_core = (cur_r >= RW'(2)) && (cur_c >= CW'(2));
      nxt_c   = col_end ? '0 : cur_c + CW'(1);
      nxt_r   = cur_r;
      if (col_end)
         nxt_r = last_px ? '0 : cur_r + RW'(1);
      lb0_rd  = lb0[cur_c];
      lb1_rd  = lb1[cur_c];
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb0[cur_c] <= lb1_rd;
         lb1[cur_c] <= pixel_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col          <= '0;
         row          <= '0;
         win_valid_o  <= 1'b0;
         frame_done_o <= 1'b0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else begin
         win_valid_o  <= accept && in_core;
         frame_done_o <= accept && last_px;
         if (accept) begin
            col <= nxt_c;
            row <= nxt_r;
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 2; c++)
                  win[r][c] <= win[r][c+1];
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= pixel_i;
         end
      end
   end

   assign data_0_0_o = win[0][0];
   assign data_0_1_o = win[0][1];
   assign data_0_2_o = win[0][2];
   assign data_1_0_o = win[1][0];
   assign data_1_1_o = win[1][1];
   assign data_1_2_o = win[1][2];
   assign data_2_0_o = win[2][0];
   assign data_2_1_o = win[2][1];
   assign data_2_2_o = win[2][2];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: vector table, corner sequences, random stream
// against a frame-image reference model.
module tb_sobel_window_gen;

   localparam int W = 4;
   localparam int H = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pixel_i = '0;
   logic       pixel_valid_i = 1'b0;
   logic       sof_i = 1'b0;
   logic [7:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
   logic       win_valid_o, frame_done_o;

   sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk(clk), .rst(rst),
      .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i), .sof_i(sof_i),
      .data_0_0_o(d00), .data_0_1_o(d01), .data_0_2_o(d02),
      .data_1_0_o(d10), .data_1_1_o(d11), .data_1_2_o(d12),
      .data_2_0_o(d20), .data_2_1_o(d21), .data_2_2_o(d22),
      .win_valid_o(win_valid_o), .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;

   logic [7:0] act [3][3];
   always_comb begin
      act[0][0] = d00; act[0][1] = d01; act[0][2] = d02;
      act[1][0] = d10; act[1][1] = d11; act[1][2] = d12;
      act[2][0] = d20; act[2][1] = d21; act[2][2] = d22;
   end

   typedef struct {
      logic [7:0] pix;
      logic       v;
      logic       s;
      logic       ewv;
      logic       efd;
      logic [7:0] e00;
      logic [7:0] e22;
   } vec_t;

   vec_t tbl [16];

   int vecs = 0;
   int errs = 0;
   int n_wv = 0;
   int n_fd = 0;

   // reference model: image in frame coordinates plus raster position
   int         mr = 0;
   int         mc = 0;
   logic [7:0] img [H][W];
   logic [7:0] ew [3][3];
   bit         known = 1'b0;
   bit         ewv = 1'b0;
   bit         efd = 1'b0;

   task automatic chk(input string nm, input int got, input int want);
      if (got != want) begin
         errs++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic check_all();
      chk("win_valid", int'(win_valid_o), int'(ewv));
      chk("frame_done", int'(frame_done_o), int'(efd));
      if (known)
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               chk($sformatf("data_%0d_%0d", i, j),
                   int'(act[i][j]), int'(ew[i][j]));
      n_wv += int'(win_valid_o);
      n_fd += int'(frame_done_o);
   endtask

   task automatic apply(input logic [7:0] p, input logic v, input logic s);
      pixel_i       = p;
      pixel_valid_i = v;
      sof_i         = s;
      @(posedge clk);
      ewv = 1'b0;
      efd = 1'b0;
      if (v) begin
         if (s) begin
            mr = 0;
            mc = 0;
         end
         img[mr][mc] = p;
         ewv   = (mr >= 2) && (mc >= 2);
         efd   = (mr == H - 1) && (mc == W - 1);
         known = ewv;
         if (ewv)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  ew[i][j] = img[mr-2+i][mc-2+j];
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end
      end
      #1;
      vecs++;
      check_all();
   endtask

   task automatic do_reset(input int n);
      rst           = 1'b1;
      pixel_valid_i = 1'b0;
      sof_i         = 1'b0;
      mr    = 0;
      mc    = 0;
      ewv   = 1'b0;
      efd   = 1'b0;
      known = 1'b1;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            ew[i][j] = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
         vecs++;
         check_all();
      end
      rst = 1'b0;
   endtask

   task automatic tv(input int k, input int pix, input bit wv,
                     input bit fd, input int e00, input int e22);
      tbl[k] = '{8'(pix), 1'b1, 1'b0, wv, fd, 8'(e00), 8'(e22)};
   endtask

   initial begin
      tv(0,  8'h00, 0, 0, 0,     0);
      tv(1,  8'h01, 0, 0, 0,     0);
      tv(2,  8'h02, 0, 0, 0,     0);
      tv(3,  8'h03, 0, 0, 0,     0);
      tv(4,  8'h10, 0, 0, 0,     0);
      tv(5,  8'h11, 0, 0, 0,     0);
      tv(6,  8'h12, 0, 0, 0,     0);
      tv(7,  8'h13, 0, 0, 0,     0);
      tv(8,  8'h20, 0, 0, 0,     0);
      tv(9,  8'h21, 0, 0, 0,     0);
      tv(10, 8'h22, 1, 0, 8'h00, 8'h22);
      tv(11, 8'h23, 1, 0, 8'h01, 8'h23);
      tv(12, 8'h30, 0, 0, 0,     0);
      tv(13, 8'h31, 0, 0, 0,     0);
      tv(14, 8'h32, 1, 0, 8'h10, 8'h32);
      tv(15, 8'h33, 1, 1, 8'h11, 8'h33);

      do_reset(3);

      // full frame from the vector table
      for (int k = 0; k < 16; k++) begin
         apply(tbl[k].pix, tbl[k].v, tbl[k].s);
         chk("tbl_wv", int'(win_valid_o), int'(tbl[k].ewv));
         chk("tbl_fd", int'(frame_done_o), int'(tbl[k].efd));
         if (tbl[k].ewv) begin
            chk("tbl_d00", int'(d00), int'(tbl[k].e00));
            chk("tbl_d22", int'(d22), int'(tbl[k].e22));
         end
      end

      // gapped valid: one accept every third cycle
      n_wv = 0;
      n_fd = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            apply(8'(16 * r + c), 1'b1, 1'b0);
            apply(8'($urandom), 1'b0, 1'b0);
            apply(8'($urandom), 1'b0, 1'b0);
         end
      chk("gap_strobes", n_wv, 4);
      chk("gap_done", n_fd, 1);

      // back-to-back frames
      n_wv = 0;
      n_fd = 0;
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               apply(8'(16 * r + c + 64 * f), 1'b1, 1'b0);
      chk("b2b_strobes", n_wv, 8);
      chk("b2b_done", n_fd, 2);

      // mid-frame sof on pixel (1,2)
      for (int k = 0; k < 6; k++)
         apply(8'(16 * (k / 4) + k % 4), 1'b1, 1'b0);
      apply(8'h12, 1'b1, 1'b1);
      n_wv = 0;
      for (int k = 0; k < 9; k++)
         apply(8'($urandom), 1'b1, 1'b0);
      chk("sof_no_early", n_wv, 0);
      apply(8'($urandom), 1'b1, 1'b0);
      chk("sof_first_win", int'(win_valid_o), 1);
      for (int k = 0; k < 5; k++)
         apply(8'($urandom), 1'b1, 1'b0);

      // reset after 9 pixels, then a clean frame
      for (int k = 0; k < 9; k++)
         apply(8'($urandom), 1'b1, 1'b0);
      do_reset(2);
      n_wv = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            apply(8'(16 * r + c), 1'b1, 1'b0);
      chk("rst_strobes", n_wv, 4);

      // random stream with gaps and occasional resync
      for (int k = 0; k < 600; k++) begin
         logic v;
         logic s;
         v = ($urandom_range(0, 2) != 0);
         s = v && ($urandom_range(0, 39) == 0);
         apply(8'($urandom), v, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
